alu_seq_loader: RTL
===================

ALU_SEQ_LOADER -- requirements
Module: alu_seq_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand, switch, result and LED width.
REQ-002 Parameter OP_WIDTH, default 6: opcode width; SHALL be <= DATA_WIDTH.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a button level change; SHALL be >= 1.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 switches  input  DATA_WIDTH  user data; sampled only on an accepted step.
REQ-007 btn_next  input  1  raw, asynchronous, bouncy step button.
REQ-008 btn_clear  input  1  raw, asynchronous, bouncy clear button.
REQ-009 alu_result  input  DATA_WIDTH  combinational result from the external ALU, driven from operand_a, operand_b and op_code.
REQ-010 operand_a, operand_b  output  DATA_WIDTH each  registered operands to the ALU.
REQ-011 op_code  output  OP_WIDTH  registered opcode to the ALU.
REQ-012 leds  output  DATA_WIDTH  display value.
REQ-013 state_leds  output  2  current FSM state encoding.
REQ-014 result_valid  output  1  high while leds shows a captured result.

Function
REQ-015 Each button SHALL pass through a 2-FF synchroniser, then a debouncer that updates its stable level only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised value; any mismatch restarts the count.
REQ-016 Each debouncer SHALL emit a one-cycle pulse on a 0->1 change of its stable level; a held button SHALL yield exactly one pulse.
REQ-017 Latency from a clean raw rising edge to the pulse SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-018 FSM states and encodings: S_A=00, S_B=01, S_OP=10, S_RES=11; state_leds SHALL equal the state.
REQ-019 S_A + next pulse: operand_a <= switches; go to S_B.
REQ-020 S_B + next pulse: operand_b <= switches; go to S_OP.
REQ-021 S_OP + next pulse: op_code <= switches[OP_WIDTH-1:0]; go to S_RES with capture_pending set.
REQ-022 In S_RES, on the first cycle with capture_pending set: result_reg <= alu_result, result_valid <= 1, capture_pending <= 0.
REQ-023 S_RES + next pulse while result_valid=1: go to S_A; result_valid <= 0; operands and opcode retained.
REQ-024 S_RES + next pulse while capture_pending=1: pulse ignored.
REQ-025 leds SHALL equal switches (live preview) in S_A, S_B and S_OP, and result_reg in S_RES.
REQ-026 Clear pulse in any state SHALL zero operand_a, operand_b, op_code and result_reg, clear result_valid and capture_pending, and go to S_A.
REQ-027 Clear and next pulses in the same cycle: clear SHALL win and next is discarded.
REQ-028 Switch changes outside an accepted step SHALL NOT alter any register.

Reset
REQ-029 While reset=1: state S_A; all operand, opcode and result registers 0; result_valid 0; capture_pending 0; synchronisers, stable levels and debounce counters 0; no pulses.
REQ-030 Reset mid-operation (any state, including during a debounce count) SHALL take full effect at the next clock edge.
REQ-031 A button held through reset deassertion SHALL produce a pulse only after a full debounce period.

Structure
REQ-032 A shared package SHALL hold the state encodings (S_A..S_RES) and the synchroniser depth constant (2).
REQ-033 Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, raw, pulse) SHALL be instantiated twice.
REQ-034 The ALU SHALL NOT be instantiated inside this block; the bench models it as alu_result = operand_a + operand_b.

Verification
REQ-035 DEBOUNCE_CYCLES=4: switches 0x05, next; 0x03, next; 0x20, next -> state_leds 11; result_valid 1 one cycle after entry to S_RES; leds 0x08.
REQ-036 btn_next glitches high for 2 cycles three times -> no pulse, state unchanged; high for 4 or more stable cycles -> one pulse exactly 6 cycles after the rising edge.
REQ-037 btn_next held for 100 cycles in S_A -> exactly one transition, to S_B.
REQ-038 In S_OP with operand_a=0x05, clear pulse -> next cycle: state 00; operand_a, operand_b, op_code 0; result_valid 0; leds = switches.
REQ-039 Clear and next pulses aligned in the same cycle in S_B -> state S_A and operand_b = 0.
REQ-040 Reset asserted in S_RES with leds=0x08 -> next cycle: state 00, result_valid 0, all registers 0.

Source files
------------

// File: rtl/alu_seq_loader_pkg.sv
// Shared definitions for the ALU sequence loader: FSM state encodings and
// button synchroniser depth.
package alu_seq_loader_pkg;

  // Number of flops in each raw-button synchroniser chain.
  localparam int unsigned SYNC_DEPTH = 2;

  // Loader states; encodings are shown directly on state_leds.
  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RES = 2'b11
  } state_e;

endpackage : alu_seq_loader_pkg

// File: rtl/alu_seq_loader_btn_debounce.sv
// Button conditioner: synchronises a raw asynchronous button, debounces it and
// emits a one-cycle pulse on each accepted press (0->1 of the stable level).
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   raw    - raw bouncy button input
//   pulse  - registered one-cycle press pulse
module btn_debounce
  import alu_seq_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  stable_q, stable_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pulse_q, pulse_d;
  logic                  synced;

  assign synced = sync_q[SYNC_DEPTH-1];

  // Next-state: shift the synchroniser, count consecutive differing cycles,
  // flip the stable level once the count completes.
  always_comb begin
    sync_d   = {sync_q[SYNC_DEPTH-2:0], raw};
    stable_d = stable_q;
    cnt_d    = '0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    pulse_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule : btn_debounce

// File: rtl/alu_seq_loader.sv
// Steps a user through loading operand A, operand B and an opcode from the
// switches into an external ALU, then captures and displays the ALU result.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   switches               - user data, sampled on an accepted step
//   btn_next, btn_clear    - raw bouncy step / clear buttons
//   alu_result             - combinational result from the external ALU
//   operand_a, operand_b   - registered ALU operands
//   op_code                - registered ALU opcode
//   leds                   - switches preview, or captured result in S_RES
//   state_leds             - current state encoding
//   result_valid           - leds is showing a captured result
module alu_seq_loader
  import alu_seq_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned OP_WIDTH        = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] switches,
  input  logic                  btn_next,
  input  logic                  btn_clear,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  output logic [OP_WIDTH-1:0]   op_code,
  output logic [DATA_WIDTH-1:0] leds,
  output logic [1:0]            state_leds,
  output logic                  result_valid
);

  logic next_pulse;
  logic clear_pulse;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] operand_a_q, operand_a_d;
  logic [DATA_WIDTH-1:0] operand_b_q, operand_b_d;
  logic [OP_WIDTH-1:0]   op_code_q, op_code_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  capture_pending_q, capture_pending_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_next),
    .pulse (next_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_clear),
    .pulse (clear_pulse)
  );

  // Next-state and datapath; clear overrides any simultaneous step.
  always_comb begin
    state_d           = state_q;
    operand_a_d       = operand_a_q;
    operand_b_d       = operand_b_q;
    op_code_d         = op_code_q;
    result_d          = result_q;
    result_valid_d    = result_valid_q;
    capture_pending_d = capture_pending_q;

    if (clear_pulse) begin
      state_d           = S_A;
      operand_a_d       = '0;
      operand_b_d       = '0;
      op_code_d         = '0;
      result_d          = '0;
      result_valid_d    = 1'b0;
      capture_pending_d = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (next_pulse) begin
            operand_a_d = switches;
            state_d     = S_B;
          end
        end
        S_B: begin
          if (next_pulse) begin
            operand_b_d = switches;
            state_d     = S_OP;
          end
        end
        S_OP: begin
          if (next_pulse) begin
            op_code_d         = switches[OP_WIDTH-1:0];
            capture_pending_d = 1'b1;
            state_d           = S_RES;
          end
        end
        S_RES: begin
          // Capture takes priority; a step during capture is dropped.
          if (capture_pending_q) begin
            result_d          = alu_result;
            result_valid_d    = 1'b1;
            capture_pending_d = 1'b0;
          end else if (next_pulse && result_valid_q) begin
            result_valid_d = 1'b0;
            state_d        = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_A;
      operand_a_q       <= '0;
      operand_b_q       <= '0;
      op_code_q         <= '0;
      result_q          <= '0;
      result_valid_q    <= 1'b0;
      capture_pending_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      operand_a_q       <= operand_a_d;
      operand_b_q       <= operand_b_d;
      op_code_q         <= op_code_d;
      result_q          <= result_d;
      result_valid_q    <= result_valid_d;
      capture_pending_q <= capture_pending_d;
    end
  end

  assign operand_a    = operand_a_q;
  assign operand_b    = operand_b_q;
  assign op_code      = op_code_q;
  assign state_leds   = 2'(state_q);
  assign result_valid = result_valid_q;
  // Live preview must follow switches without a cycle of lag.
  assign leds         = (state_q == S_RES) ? result_q : switches;

endmodule : alu_seq_loader
